// File: rtl/alu_dbg_pkg.sv
// Shared definitions for the ALU debug/observation blocks.
//   TS_W_DEF  : default timestamp width
//   DEPTH_DEF : default event FIFO depth
//   event_t   : one captured level change, level in the MSB above its timestamp
package alu_dbg_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;

    // "time" is a reserved word, hence time_tag.
    typedef struct packed {
        logic                level;
        logic [TS_W_DEF-1:0] time_tag;
    } event_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterized show-ahead synchronous FIFO.
//   clk    : rising-edge clock
//   rst_b  : synchronous reset, active-low; empties the FIFO
//   push   : write wdata (accepted when not full, or when full with a pop)
//   wdata  : write data
//   pop    : remove head entry (ignored when empty)
//   rdata  : head entry, valid while empty==0
//   full   : count==DEPTH
//   empty  : count==0
//   count  : entries held, 0..DEPTH
// DEPTH must be a power of 2 (pointers wrap by natural overflow) and >= 2.
module sync_fifo #(
    parameter int  WIDTH  = 17,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot
    // in the same cycle; the write lands on the slot being vacated.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through rd_ptr
    // while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/edge_event_capture.sv
// Observer for a single-bit synchronous signal. Every level change of D_in
// (while enabled) is tagged with a free-running timestamp and queued in a
// show-ahead FIFO that a consumer drains via Rd_valid/Rd_ready.
//   Clk      : rising-edge clock
//   Reset    : synchronous reset, active-low
//   En       : capture enable; timestamp advances and edges are recorded only when 1
//   D_in     : observed signal, synchronous to Clk
//   Clr_ovf  : pulse clearing Overflow (a same-cycle drop wins)
//   Rd_ready : consumer accepts head entry
//   Rd_valid : FIFO not empty
//   Rd_level : level of D_in after the head edge (0 when empty)
//   Rd_time  : timestamp of the head edge (0 when empty)
//   Count    : entries held, 0..DEPTH
//   Overflow : sticky, an edge was dropped because the FIFO was full
module edge_event_capture
    import alu_dbg_pkg::*;
#(
    parameter int  TS_W   = TS_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              D_in,
    input  logic              Clr_ovf,
    input  logic              Rd_ready,
    output logic              Rd_valid,
    output logic              Rd_level,
    output logic [TS_W-1:0]   Rd_time,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow
);

    logic [TS_W-1:0] ts_q;
    logic            d_prev;
    logic            ovf_q;
    logic            edge_det;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;
    logic [TS_W:0]   fifo_rdata;

    assign edge_det = En && (D_in != d_prev);
    assign fifo_pop = !fifo_empty && Rd_ready;
    // Full with a simultaneous pop still accepts the new entry.
    assign drop     = edge_det && fifo_full && !fifo_pop;

    // d_prev tracks D_in even while disabled so that enabling never sees a
    // stale level and reports a spurious edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ts_q   <= '0;
            d_prev <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            d_prev <= D_in;
            if (En) ts_q <= ts_q + 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (Clr_ovf) ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (TS_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_b (Reset),
        .push  (edge_det),
        .wdata ({D_in, ts_q}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Count)
    );

    assign Rd_valid = !fifo_empty;
    assign Rd_level = Rd_valid ? fifo_rdata[TS_W]     : 1'b0;
    assign Rd_time  = Rd_valid ? fifo_rdata[TS_W-1:0] : '0;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_edge_event_capture.sv
module tb_edge_event_capture;

    localparam int TS_W  = 16;
    localparam int DEPTH = 8;

    logic            Clk = 1'b0;
    logic            Reset, En, D_in, Clr_ovf, Rd_ready;
    logic            Rd_valid, Rd_level, Overflow;
    logic [TS_W-1:0] Rd_time;
    logic [3:0]      Count;

    logic            reset4, en4, d4, clr4, rdy4;
    logic            valid4, level4, ovf4;
    logic [3:0]      time4;
    logic [3:0]      count4;

    always #5 Clk = ~Clk;

    edge_event_capture #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .D_in(D_in), .Clr_ovf(Clr_ovf),
        .Rd_ready(Rd_ready), .Rd_valid(Rd_valid), .Rd_level(Rd_level),
        .Rd_time(Rd_time), .Count(Count), .Overflow(Overflow)
    );

    edge_event_capture #(.TS_W(4), .DEPTH(DEPTH)) dut4 (
        .Clk(Clk), .Reset(reset4), .En(en4), .D_in(d4), .Clr_ovf(clr4),
        .Rd_ready(rdy4), .Rd_valid(valid4), .Rd_level(level4),
        .Rd_time(time4), .Count(count4), .Overflow(ovf4)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {level, timestamp} pushed when an edge is driven into the
    // main DUT, popped when the consumer handshake completes.
    logic [TS_W:0]   sb [$];
    logic [TS_W-1:0] m_ts   = '0;
    logic            m_prev = 1'b0;
    logic            m_ovf  = 1'b0;
    logic [TS_W-1:0] ovf_t0 = '0;

    always @(posedge Clk) begin : model
        logic full_pre, m_edge, m_pop, m_drop;
        full_pre = (sb.size() == DEPTH);
        m_edge   = En && (D_in != m_prev);
        m_pop    = (sb.size() != 0) && Rd_ready;
        m_drop   = m_edge && full_pre && !m_pop;
        if (!Reset) begin
            sb.delete();
            m_ts   = '0;
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_edge && !m_drop) sb.push_back({D_in, m_ts});
            if (m_drop)       m_ovf = 1'b1;
            else if (Clr_ovf) m_ovf = 1'b0;
            m_prev = D_in;
            if (En) m_ts = m_ts + 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        checks++; if (Rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Rd_valid); end
        checks++; if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
        checks++; if (Rd_time !== 16'd0) begin failures++; $display("FAIL reset_time got=%0d exp=0", Rd_time); end
        Reset = 1'b1;
        En    = 1'b1;
        D_in  = 1'b0;
        repeat (10) tick();
        checks++; if (Rd_valid !== 1'b0 || Count !== 4'd0) begin failures++; $display("FAIL idle_empty valid=%b count=%0d exp 0/0", Rd_valid, Count); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b exp=0", Overflow); end
        checks++; if (dut.ts_q !== 16'd10) begin failures++; $display("FAIL idle_ts got=%0d exp=10", dut.ts_q); end
    endtask

    task automatic test_single();
        repeat (25) tick();
        D_in = 1'b1;
        tick();
        checks++; if (Rd_valid !== 1'b1 || Rd_level !== 1'b1) begin failures++; $display("FAIL single_head valid=%b level=%b exp 1/1", Rd_valid, Rd_level); end
        checks++; if (Rd_time !== 16'd35) begin failures++; $display("FAIL single_time got=%0d exp=35", Rd_time); end
        checks++; if (Count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", Count); end
        Rd_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL single_sb got=empty_scoreboard exp=one_entry"); end
        else if ({Rd_level, Rd_time} !== sb[0]) begin failures++; $display("FAIL single_sb got=%h exp=%h", {Rd_level, Rd_time}, sb[0]); end
        tick();
        Rd_ready = 1'b0;
        checks++; if (Rd_valid !== 1'b0 || Count !== 4'd0 || Rd_time !== 16'd0) begin failures++; $display("FAIL single_pop valid=%b count=%0d time=%0d exp 0/0/0", Rd_valid, Count, Rd_time); end
    endtask

    task automatic test_overflow();
        En   = 1'b0;
        D_in = 1'b0;
        tick();
        En = 1'b1;
        ovf_t0 = m_ts;
        for (int i = 0; i < 9; i++) begin
            D_in = ~D_in;
            tick();
        end
        checks++; if (Count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", Count); end
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", Overflow); end
        checks++; if (int'(Count) != sb.size() || Overflow !== m_ovf) begin failures++; $display("FAIL ovf_model count=%0d ovf=%b exp %0d/%b", Count, Overflow, sb.size(), m_ovf); end
        Clr_ovf = 1'b1;
        tick();
        Clr_ovf = 1'b0;
        checks++; if (Overflow !== 1'b0 || Count !== 4'd8) begin failures++; $display("FAIL ovf_clear ovf=%b count=%0d exp 0/8", Overflow, Count); end
    endtask

    task automatic test_full_pop();
        checks++; if (Rd_level !== 1'b1 || Rd_time !== ovf_t0) begin failures++; $display("FAIL fullpop_head level=%b time=%0d exp 1/%0d", Rd_level, Rd_time, ovf_t0); end
        Rd_ready = 1'b1;
        D_in     = ~D_in;
        tick();
        Rd_ready = 1'b0;
        checks++; if (Count !== 4'd8) begin failures++; $display("FAIL fullpop_count got=%0d exp=8", Count); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%b exp=0", Overflow); end
    endtask

    task automatic test_drain();
        logic            exp_lvl;
        logic [TS_W-1:0] exp_t;
        Rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            // Entries 0..6 are the 2nd..8th toggles; the last is the edge
            // pushed while full-with-pop.
            exp_lvl = (j == 7) ? 1'b0 : ((j % 2) == 0 ? 1'b0 : 1'b1);
            exp_t   = (j == 7) ? TS_W'(ovf_t0 + 10) : TS_W'(ovf_t0 + j + 1);
            checks++;
            if (Rd_valid !== 1'b1 || Rd_level !== exp_lvl || Rd_time !== exp_t) begin
                failures++;
                $display("FAIL drain_%0d valid=%b level=%b time=%0d exp 1/%b/%0d", j, Rd_valid, Rd_level, Rd_time, exp_lvl, exp_t);
            end
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL drain_sb_%0d got=empty_scoreboard exp=entry", j); end
            else if ({Rd_level, Rd_time} !== sb[0]) begin failures++; $display("FAIL drain_sb_%0d got=%h exp=%h", j, {Rd_level, Rd_time}, sb[0]); end
            tick();
        end
        Rd_ready = 1'b0;
        checks++; if (Rd_valid !== 1'b0 || Count !== 4'd0 || Rd_level !== 1'b0 || Rd_time !== 16'd0) begin failures++; $display("FAIL drain_empty valid=%b count=%0d level=%b time=%0d exp 0/0/0/0", Rd_valid, Count, Rd_level, Rd_time); end
    endtask

    task automatic test_empty_edge_ready();
        Rd_ready = 1'b1;
        D_in     = ~D_in;
        tick();
        checks++; if (Count !== 4'd1 || Rd_valid !== 1'b1 || Rd_level !== D_in) begin failures++; $display("FAIL empty_edge count=%0d valid=%b level=%b exp 1/1/%b", Count, Rd_valid, Rd_level, D_in); end
        tick();
        Rd_ready = 1'b0;
        checks++; if (Count !== 4'd0 || Rd_valid !== 1'b0) begin failures++; $display("FAIL empty_edge_pop count=%0d valid=%b exp 0/0", Count, Rd_valid); end
    endtask

    task automatic test_disable();
        logic [TS_W-1:0] t_sav;
        t_sav = m_ts;
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D_in = ~D_in;
            tick();
        end
        checks++; if (Count !== 4'd0 || Rd_valid !== 1'b0) begin failures++; $display("FAIL dis_entries count=%0d valid=%b exp 0/0", Count, Rd_valid); end
        checks++; if (dut.ts_q !== t_sav) begin failures++; $display("FAIL dis_ts got=%0d exp=%0d", dut.ts_q, t_sav); end
        En = 1'b1;
        tick();
        tick();
        checks++; if (Count !== 4'd0) begin failures++; $display("FAIL dis_spurious count=%0d exp=0", Count); end
        checks++; if (dut.ts_q !== TS_W'(t_sav + 2)) begin failures++; $display("FAIL dis_resume_ts got=%0d exp=%0d", dut.ts_q, TS_W'(t_sav + 2)); end
    endtask

    task automatic test_wrap();
        int n;
        reset4 = 1'b0;
        tick();
        reset4 = 1'b1;
        en4    = 1'b1;
        d4     = 1'b0;
        n      = 0;
        while (dut4.ts_q !== 4'd15 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (dut4.ts_q !== 4'd15) begin failures++; $display("FAIL wrap_reach ts=%0d exp=15 within 40 cycles", dut4.ts_q); end
        d4 = 1'b1;
        tick();
        d4 = 1'b0;
        tick();
        checks++; if (count4 !== 4'd2 || valid4 !== 1'b1) begin failures++; $display("FAIL wrap_count count=%0d valid=%b exp 2/1", count4, valid4); end
        checks++; if (level4 !== 1'b1 || time4 !== 4'd15) begin failures++; $display("FAIL wrap_first level=%b time=%0d exp 1/15", level4, time4); end
        rdy4 = 1'b1;
        tick();
        checks++; if (level4 !== 1'b0 || time4 !== 4'd0) begin failures++; $display("FAIL wrap_second level=%b time=%0d exp 0/0", level4, time4); end
        tick();
        rdy4 = 1'b0;
        checks++; if (count4 !== 4'd0 || valid4 !== 1'b0) begin failures++; $display("FAIL wrap_drain count=%0d valid=%b exp 0/0", count4, valid4); end
    endtask

    task automatic test_mid_reset();
        Rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D_in = ~D_in;
            tick();
        end
        checks++; if (Count !== 4'd3) begin failures++; $display("FAIL mid_fill count=%0d exp=3", Count); end
        Reset    = 1'b0;
        Rd_ready = 1'b1;
        D_in     = ~D_in;
        tick();
        Reset    = 1'b1;
        Rd_ready = 1'b0;
        checks++; if (Count !== 4'd0 || Rd_valid !== 1'b0) begin failures++; $display("FAIL mid_reset count=%0d valid=%b exp 0/0", Count, Rd_valid); end
        checks++; if (Rd_time !== 16'd0 || Overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_out time=%0d ovf=%b exp 0/0", Rd_time, Overflow); end
        checks++; if (dut.ts_q !== 16'd0) begin failures++; $display("FAIL mid_reset_ts got=%0d exp=0", dut.ts_q); end
    endtask

    initial begin
        Reset = 1'b0; En = 1'b0; D_in = 1'b0; Clr_ovf = 1'b0; Rd_ready = 1'b0;
        reset4 = 1'b0; en4 = 1'b0; d4 = 1'b0; clr4 = 1'b0; rdy4 = 1'b0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_drain();
        test_empty_edge_ready();
        test_disable();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time_limit_reached exp=finish_before_100000");
        $fatal(1, "watchdog");
    end

endmodule
